// File: rtl/hdmi_tmds_pkg.sv
// Shared TMDS definitions: control tokens, token-to-ctrl mapping and
// the 10b->8b data decode. The transmit-side encoder reuses this package.
package hdmi_tmds_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    function automatic logic is_ctrl_token(input logic [9:0] w);
        return (w == TOKEN_C00) || (w == TOKEN_C01) ||
               (w == TOKEN_C10) || (w == TOKEN_C11);
    endfunction

    // {c1,c0} carried by a control token; 00 for anything else
    function automatic logic [1:0] ctrl_of_token(input logic [9:0] w);
        logic [1:0] c;
        case (w)
            TOKEN_C01: c = 2'b01;
            TOKEN_C10: c = 2'b10;
            TOKEN_C11: c = 2'b11;
            default:   c = 2'b00;
        endcase
        return c;
    endfunction

    // q[9] flags an inverted payload, q[8] selects XOR vs XNOR chaining
    function automatic logic [7:0] tmds_decode8(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] o;
        d    = q[9] ? ~q[7:0] : q[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

endpackage

// File: rtl/tmds_symbol_aligner.sv
// Symbol alignment: two-word input pipeline, barrel select over the
// 20-bit history, token detect and the SEARCH/LOCKED alignment FSM.
// Ports: clk, rst, in_bits[9:0] in; word[9:0], is_token, token_ctrl[1:0],
//        aligned, bit_offset[3:0] out.
module tmds_symbol_aligner
    import hdmi_tmds_pkg::*;
#(
    parameter int LOCK_RUN  = 8,
    parameter int SLIP_WAIT = 2048,
    parameter int WATCHDOG  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] in_bits,
    output logic [9:0] word,
    output logic       is_token,
    output logic [1:0] token_ctrl,
    output logic       aligned,
    output logic [3:0] bit_offset
);

    localparam int TMAX = (SLIP_WAIT > WATCHDOG) ? SLIP_WAIT : WATCHDOG;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int RW   = $clog2(LOCK_RUN + 1);

    logic [9:0]    in_q;
    logic [9:0]    in_qq;
    logic [19:0]   hist;
    logic [TW-1:0] timer;
    logic [RW-1:0] run;
    align_state_t  state;
    logic          lock_due;
    logic          slip_due;
    logic          dog_due;

    // in_qq holds the older word, so offset 0 selects in_qq unchanged
    assign hist       = {in_q, in_qq};
    assign word       = 10'(hist >> bit_offset);
    assign is_token   = is_ctrl_token(word);
    assign token_ctrl = ctrl_of_token(word);

    assign lock_due = is_token && (run == RW'(LOCK_RUN - 1));
    assign slip_due = (timer == TW'(SLIP_WAIT - 1));
    assign dog_due  = !is_token && (timer == TW'(WATCHDOG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q       <= '0;
            in_qq      <= '0;
            state      <= SEARCH;
            aligned    <= 1'b0;
            bit_offset <= '0;
            run        <= '0;
            timer      <= '0;
        end else begin
            in_q  <= in_bits;
            in_qq <= in_q;
            case (state)
                SEARCH: begin
                    // lock takes priority over a coincident slip
                    if (lock_due) begin
                        state   <= LOCKED;
                        aligned <= 1'b1;
                        run     <= '0;
                        timer   <= '0;
                    end else if (slip_due) begin
                        bit_offset <= (bit_offset == 4'd9) ? 4'd0
                                                           : bit_offset + 4'd1;
                        run        <= '0;
                        timer      <= '0;
                    end else begin
                        run   <= is_token ? run + 1'b1 : '0;
                        timer <= timer + 1'b1;
                    end
                end
                LOCKED: begin
                    if (is_token) begin
                        timer <= '0;
                    end else if (dog_due) begin
                        state   <= SEARCH;
                        aligned <= 1'b0;
                        run     <= '0;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state   <= SEARCH;
                    aligned <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hdmi_tmds_decoder.sv
// Single-channel TMDS receive decoder: aligner plus registered decode stage.
// Ports: clk, rst, in_bits[9:0] in; data[7:0], ctrl[1:0], de, aligned,
//        bit_offset[3:0] out.
module hdmi_tmds_decoder
    import hdmi_tmds_pkg::*;
#(
    parameter int LOCK_RUN  = 8,
    parameter int SLIP_WAIT = 2048,
    parameter int WATCHDOG  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] in_bits,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       aligned,
    output logic [3:0] bit_offset
);

    logic [9:0] word;
    logic       is_token;
    logic [1:0] token_ctrl;

    tmds_symbol_aligner #(
        .LOCK_RUN  (LOCK_RUN),
        .SLIP_WAIT (SLIP_WAIT),
        .WATCHDOG  (WATCHDOG)
    ) u_align (
        .clk        (clk),
        .rst        (rst),
        .in_bits    (in_bits),
        .word       (word),
        .is_token   (is_token),
        .token_ctrl (token_ctrl),
        .aligned    (aligned),
        .bit_offset (bit_offset)
    );

    // gated on the pre-edge lock state, so the locking edge still emits 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            ctrl <= '0;
            de   <= 1'b0;
        end else if (!aligned) begin
            data <= '0;
            ctrl <= '0;
            de   <= 1'b0;
        end else if (is_token) begin
            data <= '0;
            ctrl <= token_ctrl;
            de   <= 1'b0;
        end else begin
            data <= tmds_decode8(word);
            de   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hdmi_tmds_decoder.sv
// Self-checking bench for hdmi_tmds_decoder: directed sequences, a
// decode vector table and randomized streams against a reference model.
module tb_hdmi_tmds_decoder;

    localparam int LOCK_RUN  = 8;
    localparam int SLIP_WAIT = 16;
    localparam int WATCHDOG  = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] in_bits = '0;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       aligned;
    logic [3:0] bit_offset;

    int checks   = 0;
    int failures = 0;

    hdmi_tmds_decoder #(
        .LOCK_RUN  (LOCK_RUN),
        .SLIP_WAIT (SLIP_WAIT),
        .WATCHDOG  (WATCHDOG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_bits    (in_bits),
        .data       (data),
        .ctrl       (ctrl),
        .de         (de),
        .aligned    (aligned),
        .bit_offset (bit_offset)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // ---------------- reference model state ----------------
    bit         m_locked;
    int         m_run;
    int         m_timer;
    int         m_off;
    logic [9:0] m_q;
    logic [9:0] m_qq;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    logic       m_de;
    logic [9:0] prev_sym;
    int         enc_cnt;

    function automatic logic [9:0] tok(input int c);
        case (c)
            0:       return 10'b1101010100;
            1:       return 10'b0010101011;
            2:       return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic int tok_index(input logic [9:0] w);
        for (int c = 0; c < 4; c++) begin
            if (w == tok(c)) return c;
        end
        return -1;
    endfunction

    // transmit-side XOR/XNOR chain
    function automatic logic [7:0] qm_of(input logic [7:0] b, input logic xm);
        logic [7:0] q;
        q[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xm ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
        end
        return q;
    endfunction

    // decode by inverting the encoder: find the byte that produced the chain
    function automatic logic [7:0] decode_ref(input logic [9:0] q);
        logic [7:0] d;
        d = q[9] ? ~q[7:0] : q[7:0];
        for (int b = 0; b < 256; b++) begin
            if (qm_of(8'(b), q[8]) == d) return 8'(b);
        end
        return 8'h00;
    endfunction

    // 10 consecutive serial bits starting m_off bits into the older word
    function automatic logic [9:0] window();
        logic [9:0] w;
        for (int j = 0; j < 10; j++) begin
            w[j] = (m_off + j < 10) ? m_qq[m_off + j] : m_q[m_off + j - 10];
        end
        return w;
    endfunction

    task automatic encode(input logic [7:0] b, output logic [9:0] q);
        int n1, n1q, n0q;
        logic xm;
        logic [7:0] qm;
        n1  = $countones(b);
        xm  = !((n1 > 4) || (n1 == 4 && b[0] == 1'b0));
        qm  = qm_of(b, xm);
        n1q = $countones(qm);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            q = {~xm, xm, xm ? qm : ~qm};
            enc_cnt += xm ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            q = {1'b1, xm, ~qm};
            enc_cnt += (xm ? 2 : 0) + (n0q - n1q);
        end else begin
            q = {1'b0, xm, qm};
            enc_cnt += (xm ? 0 : -2) + (n1q - n0q);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_timer = 0; m_off = 0;
        m_q = '0; m_qq = '0; m_data = '0; m_ctrl = '0; m_de = 1'b0;
        prev_sym = '0; enc_cnt = 0;
    endtask

    task automatic model_edge(input logic [9:0] w);
        logic [9:0] win;
        int t;
        win = window();
        t   = tok_index(win);
        if (!m_locked) begin
            m_de = 0; m_data = '0; m_ctrl = '0;
        end else if (t >= 0) begin
            m_de = 0; m_data = '0; m_ctrl = t[1:0];
        end else begin
            m_de = 1; m_data = decode_ref(win);
        end
        if (!m_locked) begin
            if (t >= 0 && m_run + 1 == LOCK_RUN) begin
                m_locked = 1; m_run = 0; m_timer = 0;
            end else if (m_timer == SLIP_WAIT - 1) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_timer = 0;
            end else begin
                m_run = (t >= 0) ? m_run + 1 : 0;
                m_timer++;
            end
        end else begin
            if (t >= 0) m_timer = 0;
            else if (m_timer == WATCHDOG - 1) begin
                m_locked = 0; m_run = 0; m_timer = 0;
            end else m_timer++;
        end
        m_qq = m_q;
        m_q  = w;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        checks++;
        if (data !== m_data || ctrl !== m_ctrl || de !== m_de ||
            aligned !== m_locked || int'(bit_offset) != m_off) begin
            failures++;
            $display("FAIL model t=%0t got d=%h c=%0d de=%b al=%b off=%0d want d=%h c=%0d de=%b al=%b off=%0d",
                     $time, data, ctrl, de, aligned, bit_offset,
                     m_data, m_ctrl, m_de, m_locked, m_off);
        end
    endtask

    task automatic step(input logic [9:0] w);
        in_bits = w;
        @(posedge clk);
        #1;
        model_edge(w);
        check_model();
    endtask

    // serialise symbol s into the stream, cut at a bit phase of k
    task automatic send_sym(input logic [9:0] s, input int k);
        logic [19:0] cat;
        cat = {s, prev_sym} >> (10 - k);
        prev_sym = s;
        step(cat[9:0]);
    endtask

    task automatic send_byte(input logic [7:0] b, input int k);
        logic [9:0] q;
        encode(b, q);
        send_sym(q, k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_bits = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit         is_tok;
        logic [7:0] val;
        logic       exp_de;
        logic [1:0] exp_ctrl;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int off_edges[$];
        int lock_edge;
        logic [3:0] last_off;
        logic [9:0] w;

        tbl[0]  = '{0, 8'h5A, 1, 2'd0, 8'h5A};
        tbl[1]  = '{1, 8'd3,  0, 2'd3, 8'h00};
        tbl[2]  = '{0, 8'h5A, 1, 2'd3, 8'h5A};
        tbl[3]  = '{0, 8'h00, 1, 2'd3, 8'h00};
        tbl[4]  = '{0, 8'hFF, 1, 2'd3, 8'hFF};
        tbl[5]  = '{1, 8'd1,  0, 2'd1, 8'h00};
        tbl[6]  = '{0, 8'h80, 1, 2'd1, 8'h80};
        tbl[7]  = '{1, 8'd2,  0, 2'd2, 8'h00};
        tbl[8]  = '{0, 8'h01, 1, 2'd2, 8'h01};
        tbl[9]  = '{1, 8'd0,  0, 2'd0, 8'h00};
        tbl[10] = '{0, 8'hC3, 1, 2'd0, 8'hC3};

        // reset values and lock at offset 0
        do_reset();
        chk("rst_data", data, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_de", de, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_offset", bit_offset, 0);
        for (int i = 1; i <= 20; i++) begin
            step(tok(0));
            if (i == 9)  chk("lock_before", aligned, 0);
            if (i == 10) chk("lock_edge", aligned, 1);
        end
        chk("lock_de", de, 0);
        chk("lock_ctrl", ctrl, 0);
        chk("lock_offset", bit_offset, 0);

        // stream rotated by 3 bits: slips every 16 cycles then locks
        do_reset();
        lock_edge = -1;
        last_off  = '0;
        for (int i = 1; i <= 60; i++) begin
            send_sym(tok(0), 3);
            if (bit_offset != last_off) off_edges.push_back(i);
            last_off = bit_offset;
            if (aligned && lock_edge < 0) lock_edge = i;
        end
        chk("slip_count", off_edges.size(), 3);
        for (int j = 0; j < 3; j++)
            chk("slip_edge", (j < off_edges.size()) ? off_edges[j] : -1, 16 * (j + 1));
        chk("rot_lock_edge", lock_edge, 56);
        chk("rot_offset", bit_offset, 3);

        // decode vector table, three-edge latency
        do_reset();
        for (int i = 0; i < 12; i++) step(tok(0));
        for (int i = 0; i < 13; i++) begin
            if (i >= 11) w = tok(0);
            else if (tbl[i].is_tok) w = tok(int'(tbl[i].val));
            else encode(tbl[i].val, w);
            step(w);
            if (i >= 2) begin
                chk("vec_de", de, tbl[i-2].exp_de);
                chk("vec_ctrl", ctrl, tbl[i-2].exp_ctrl);
                chk("vec_data", data, tbl[i-2].exp_data);
            end
        end

        // watchdog: 64 data words without a token drop the lock
        step(tok(3));
        for (int d = 1; d <= 70; d++) begin
            send_byte(8'($urandom_range(0, 255)), 0);
            if (d == 65) begin
                chk("wd_still_locked", aligned, 1);
                chk("wd_ctrl_held", ctrl, 3);
            end
            if (d == 66) begin
                chk("wd_drop", aligned, 0);
                chk("wd_last_de", de, 1);
            end
            if (d == 67) begin
                chk("wd_de_zero", de, 0);
                chk("wd_ctrl_zero", ctrl, 0);
                chk("wd_data_zero", data, 0);
                chk("wd_offset_kept", bit_offset, 0);
            end
        end

        // lock and slip in the same cycle: lock wins
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step((i <= 6) ? 10'h000 : tok(0));
            if (i == 15) chk("coin_pre_lock", aligned, 0);
            if (i == 16) begin
                chk("coin_lock", aligned, 1);
                chk("coin_offset", bit_offset, 0);
            end
            if (i == 17) chk("coin_offset_hold", bit_offset, 0);
        end

        // offset wraps 9 -> 0, then async reset while locked
        do_reset();
        for (int i = 1; i <= 160; i++) begin
            step(10'h000);
            if (i == 144) chk("wrap_at9", bit_offset, 9);
            if (i == 159) chk("wrap_hold9", bit_offset, 9);
            if (i == 160) chk("wrap_to0", bit_offset, 0);
        end
        for (int i = 0; i < 12; i++) step(tok(0));
        step(tok(2));
        send_byte(8'h3C, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h11, 0);
        chk("pre_rst_de", de, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_data", data, 0);
        chk("arst_ctrl", ctrl, 0);
        chk("arst_de", de, 0);
        chk("arst_aligned", aligned, 0);
        chk("arst_offset", bit_offset, 0);
        do_reset();

        // randomized streams at random bit phase
        for (int r = 0; r < 3; r++) begin
            int k;
            do_reset();
            k = $urandom_range(0, 9);
            for (int i = 0; i < 170; i++) send_sym(tok(0), k);
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 5) == 0) send_sym(tok($urandom_range(0, 3)), k);
                else send_byte(8'($urandom_range(0, 255)), k);
            end
            chk("rand_locked", aligned, 1);
            chk("rand_offset", bit_offset, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
